// File: rtl/mm_core_pkg.sv
// mm_core_pkg: opcodes, FSM state encoding and default widths shared by the core and its ALU.
package mm_core_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int PC_W_DEF    = 8;
    localparam int DRAM_DW_DEF = 8;
    localparam int IR_W        = 8;

    localparam logic [IR_W-1:0] OP_NOP    = 8'h00;
    localparam logic [IR_W-1:0] OP_LDAC   = 8'h04;
    localparam logic [IR_W-1:0] OP_LDIM   = 8'h08;
    localparam logic [IR_W-1:0] OP_STAC   = 8'h0B;
    localparam logic [IR_W-1:0] OP_CLAC   = 8'h14;
    localparam logic [IR_W-1:0] OP_MVACR  = 8'h15;
    localparam logic [IR_W-1:0] OP_MVRAC  = 8'h16;
    localparam logic [IR_W-1:0] OP_MVACAR = 8'h17;
    localparam logic [IR_W-1:0] OP_ADD    = 8'h18;
    localparam logic [IR_W-1:0] OP_SUB    = 8'h19;
    localparam logic [IR_W-1:0] OP_MUL    = 8'h1A;
    localparam logic [IR_W-1:0] OP_INAC   = 8'h1B;
    localparam logic [IR_W-1:0] OP_DCAC   = 8'h1C;
    localparam logic [IR_W-1:0] OP_INAR   = 8'h1D;
    localparam logic [IR_W-1:0] OP_JPNZ   = 8'h2B;
    localparam logic [IR_W-1:0] OP_END    = 8'hFF;

    typedef enum logic [2:0] {
        FETCH1,
        FETCH2,
        DECODE,
        EX1,
        EX2,
        HALT
    } state_t;

endpackage

// File: rtl/mm_alu.sv
// mm_alu: single-cycle accumulator operations; flags which opcodes write AC and update Z.
module mm_alu
    import mm_core_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [IR_W-1:0]   op,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] r,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              writes_ac
);

    // Arithmetic wraps modulo 2^DATA_W; MUL keeps only the low half of the product.
    always_comb begin
        result    = ac;
        writes_ac = 1'b1;
        case (op)
            OP_CLAC: result = '0;
            OP_ADD:  result = ac + r;
            OP_SUB:  result = ac - r;
            OP_MUL:  result = ac * r;
            OP_INAC: result = ac + DATA_W'(1);
            OP_DCAC: result = ac - DATA_W'(1);
            default: writes_ac = 1'b0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/mm_core.sv
// mm_core: 16-bit accumulator processor; fetch/decode/execute FSM over external IRAM and DRAM.
module mm_core
    import mm_core_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int DRAM_DW = DRAM_DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               status,
    input  logic [IR_W-1:0]    iram_out,
    input  logic [DRAM_DW-1:0] dram_out,
    output logic               dram_wrEn,
    output logic               read_IRAM,
    output logic [PC_W-1:0]    pc_out,
    output logic [DATA_W-1:0]  ar_out,
    output logic [DATA_W-1:0]  bus_out,
    output logic               end_process
);

    state_t            state;
    logic [DATA_W-1:0] ac;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] ar;
    logic [DATA_W-1:0] bus;
    logic [PC_W-1:0]   pc;
    logic [IR_W-1:0]   ir;
    logic              z;
    logic              end_p;

    logic [DATA_W-1:0] alu_res;
    logic              alu_zero;
    logic              alu_writes;
    logic [DATA_W-1:0] iram_ext;
    logic [DATA_W-1:0] dram_ext;

    assign iram_ext = DATA_W'(iram_out);
    assign dram_ext = DATA_W'(dram_out);

    mm_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op        (ir),
        .ac        (ac),
        .r         (r),
        .result    (alu_res),
        .zero      (alu_zero),
        .writes_ac (alu_writes)
    );

    // Main FSM: one instruction at a time, register-transfer ops finish in DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH1;
            ac    <= '0;
            r     <= '0;
            ar    <= '0;
            bus   <= '0;
            pc    <= '0;
            ir    <= '0;
            z     <= 1'b0;
            end_p <= 1'b0;
        end else begin
            case (state)
                FETCH1: begin
                    if (status) state <= FETCH2;
                end
                FETCH2: begin
                    ir    <= iram_out;
                    pc    <= pc + PC_W'(1);
                    state <= DECODE;
                end
                DECODE: begin
                    state <= FETCH1;
                    case (ir)
                        OP_NOP: ;
                        OP_LDAC, OP_LDIM, OP_JPNZ: state <= EX1;
                        OP_STAC: begin
                            // bus must carry AC during the write cycle that follows
                            bus   <= ac;
                            state <= EX1;
                        end
                        OP_MVACR: begin
                            r   <= ac;
                            bus <= ac;
                        end
                        OP_MVRAC: begin
                            ac  <= r;
                            bus <= r;
                        end
                        OP_MVACAR: begin
                            ar  <= ac;
                            bus <= ac;
                        end
                        OP_INAR: begin
                            ar  <= ar + DATA_W'(1);
                            bus <= ar + DATA_W'(1);
                        end
                        OP_END: begin
                            end_p <= 1'b1;
                            state <= HALT;
                        end
                        default: begin
                            // unknown opcodes fall through here with alu_writes low
                            if (alu_writes) begin
                                ac  <= alu_res;
                                bus <= alu_res;
                                z   <= alu_zero;
                            end
                        end
                    endcase
                end
                EX1: begin
                    if (ir == OP_STAC) state <= FETCH1;
                    else               state <= EX2;
                end
                EX2: begin
                    state <= FETCH1;
                    case (ir)
                        OP_LDAC: begin
                            ac  <= dram_ext;
                            bus <= dram_ext;
                        end
                        OP_LDIM: begin
                            ac  <= iram_ext;
                            bus <= iram_ext;
                            pc  <= pc + PC_W'(1);
                        end
                        OP_JPNZ: begin
                            if (!z) pc <= PC_W'(iram_out);
                            else    pc <= pc + PC_W'(1);
                        end
                        default: ;
                    endcase
                end
                HALT: state <= HALT;
                default: state <= FETCH1;
            endcase
        end
    end

    // Memory strobes decode from the current state so the external RAMs see them in the same cycle.
    always_comb begin
        read_IRAM = 1'b0;
        dram_wrEn = 1'b0;
        if (!rst) begin
            case (state)
                FETCH1: read_IRAM = status;
                EX1: begin
                    read_IRAM = (ir == OP_LDIM) || (ir == OP_JPNZ);
                    dram_wrEn = (ir == OP_STAC);
                end
                default: ;
            endcase
        end
    end

    assign pc_out      = pc;
    assign ar_out      = ar;
    assign bus_out     = bus;
    assign end_process = end_p;

endmodule

// File: tb/tb_mm_core.sv
// tb_mm_core: directed program table plus hand sequences for reset, status gating and abort.
module tb_mm_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        status;
    logic [7:0]  iram_out = 8'h00;
    logic [7:0]  dram_out = 8'h00;
    logic        dram_wrEn;
    logic        read_IRAM;
    logic [7:0]  pc_out;
    logic [15:0] ar_out;
    logic [15:0] bus_out;
    logic        end_process;

    logic [7:0]  iram [256];
    logic        clr_wr;
    int          wr_cnt = 0;
    logic [15:0] wr_addr = 16'h0;
    logic [15:0] wr_data = 16'h0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [127:0] prog;
        logic [15:0] ar;
        logic [15:0] bus;
        logic [7:0]  pc;
        int          wr;
        logic [15:0] waddr;
        logic [15:0] wdata;
    } vec_t;

    localparam int NV = 9;
    vec_t vec [NV];

    mm_core dut (
        .clk         (clk),
        .rst         (rst),
        .status      (status),
        .iram_out    (iram_out),
        .dram_out    (dram_out),
        .dram_wrEn   (dram_wrEn),
        .read_IRAM   (read_IRAM),
        .pc_out      (pc_out),
        .ar_out      (ar_out),
        .bus_out     (bus_out),
        .end_process (end_process)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dram_val(input logic [7:0] a);
        case (a)
            8'h05:   return 8'h23;
            8'h07:   return 8'hC8;
            default: return 8'h00;
        endcase
    endfunction

    // Synchronous IRAM/DRAM models with a write logger.
    always @(posedge clk) begin
        if (read_IRAM) iram_out <= iram[pc_out];
        dram_out <= dram_val(ar_out[7:0]);
        if (clr_wr) begin
            wr_cnt <= 0;
        end else if (dram_wrEn) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= ar_out;
            wr_data <= bus_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [127:0] p);
        for (int a = 0; a < 256; a++)
            iram[a] = (a < 16) ? p[127-8*a -: 8] : 8'hFF;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        status = 1'b0;
        clr_wr = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        clr_wr = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (end_process) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit          ok;
        logic [7:0]  pc_hold;
        int          wr_hold;
        bit          found;

        rst    = 1'b1;
        status = 1'b0;
        clr_wr = 1'b1;
        for (int a = 0; a < 256; a++) iram[a] = 8'hFF;

        vec[0] = '{"ldim_stac", 128'h08_23_17_0B_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF,
                   16'h0023, 16'h0023, 8'h05, 1, 16'h0023, 16'h0023};
        vec[1] = '{"ldac_clac", 128'h08_05_17_04_17_14_2B_00_0B_FF_FF_FF_FF_FF_FF_FF,
                   16'h0023, 16'h0000, 8'h0A, 1, 16'h0023, 16'h0000};
        vec[2] = '{"mul_jump",  128'h08_05_15_08_03_1A_2B_0A_FF_FF_17_FF_FF_FF_FF_FF,
                   16'h000F, 16'h000F, 8'h0C, 0, 16'h0000, 16'h0000};
        vec[3] = '{"sub_fall",  128'h08_03_15_08_03_19_2B_00_17_FF_FF_FF_FF_FF_FF_FF,
                   16'h0000, 16'h0000, 8'h0A, 0, 16'h0000, 16'h0000};
        vec[4] = '{"dcac_loop", 128'h08_02_1C_2B_02_17_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF,
                   16'h0000, 16'h0000, 8'h07, 0, 16'h0000, 16'h0000};
        vec[5] = '{"dcac_wrap", 128'h14_1C_2B_06_FF_FF_17_FF_FF_FF_FF_FF_FF_FF_FF_FF,
                   16'hFFFF, 16'hFFFF, 8'h08, 0, 16'h0000, 16'h0000};
        vec[6] = '{"add_inar",  128'h08_10_15_08_22_18_1B_0B_16_17_1D_FF_FF_FF_FF_FF,
                   16'h0011, 16'h0011, 8'h0C, 1, 16'h0000, 16'h0033};
        vec[7] = '{"nop_zext",  128'h08_F0_00_3C_17_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF,
                   16'h00F0, 16'h00F0, 8'h06, 0, 16'h0000, 16'h0000};
        vec[8] = '{"mul_wrap",  128'h08_FF_15_1A_17_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF,
                   16'hFE01, 16'hFE01, 8'h06, 0, 16'h0000, 16'h0000};

        // Reset state and status gating
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst.pc", pc_out, 0);
        chk("rst.ar", ar_out, 0);
        chk("rst.bus", bus_out, 0);
        chk("rst.rd", read_IRAM, 0);
        chk("rst.wr", dram_wrEn, 0);
        chk("rst.end", end_process, 0);
        rst    = 1'b0;
        clr_wr = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle.pc", pc_out, 0);
        chk("idle.rd", read_IRAM, 0);
        status = 1'b1;
        #1;
        chk("go.rd", read_IRAM, 1);
        chk("go.pc", pc_out, 0);
        wait_end(50, ok);
        chk("go.done", ok, 1);
        chk("go.pc_end", pc_out, 8'h01);

        // Dropping status mid-instruction: LDIM finishes, then the core parks in FETCH1
        do_reset();
        load(128'h08_23_17_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF);
        status = 1'b1;
        @(negedge clk);
        status = 1'b0;
        repeat (10) @(negedge clk);
        chk("park.pc", pc_out, 8'h02);
        chk("park.bus", bus_out, 16'h0023);
        chk("park.rd", read_IRAM, 0);
        chk("park.end", end_process, 0);
        status = 1'b1;
        wait_end(100, ok);
        chk("park.done", ok, 1);
        chk("park.ar", ar_out, 16'h0023);

        // Program table
        for (int v = 0; v < NV; v++) begin
            do_reset();
            load(vec[v].prog);
            status = 1'b1;
            wait_end(2000, ok);
            chk($sformatf("%s.done", vec[v].name), ok, 1);
            chk($sformatf("%s.ar", vec[v].name), ar_out, vec[v].ar);
            chk($sformatf("%s.bus", vec[v].name), bus_out, vec[v].bus);
            chk($sformatf("%s.pc", vec[v].name), pc_out, vec[v].pc);
            chk($sformatf("%s.nwr", vec[v].name), wr_cnt, vec[v].wr);
            if (vec[v].wr > 0) begin
                chk($sformatf("%s.waddr", vec[v].name), wr_addr, vec[v].waddr);
                chk($sformatf("%s.wdata", vec[v].name), wr_data, vec[v].wdata);
            end
            pc_hold = pc_out;
            wr_hold = wr_cnt;
            repeat (6) @(negedge clk);
            chk($sformatf("%s.halt_end", vec[v].name), end_process, 1);
            chk($sformatf("%s.halt_pc", vec[v].name), pc_out, pc_hold);
            chk($sformatf("%s.halt_rd", vec[v].name), read_IRAM, 0);
            chk($sformatf("%s.halt_nwr", vec[v].name), wr_cnt, wr_hold);
        end

        // Reset asserted during LDAC EX1 aborts it and refetches from 0
        do_reset();
        load(128'h08_05_17_04_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF);
        status = 1'b1;
        found  = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (pc_out == 8'h04) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort.reach", found, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.pc", pc_out, 0);
        chk("abort.ar", ar_out, 0);
        chk("abort.bus", bus_out, 0);
        chk("abort.rd", read_IRAM, 0);
        chk("abort.wr", dram_wrEn, 0);
        chk("abort.end", end_process, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort.refetch_rd", read_IRAM, 1);
        chk("abort.refetch_pc", pc_out, 0);
        wait_end(200, ok);
        chk("abort.done", ok, 1);
        chk("abort.ar_end", ar_out, 16'h0005);
        chk("abort.bus_end", bus_out, 16'h0023);
        chk("abort.pc_end", pc_out, 8'h05);
        chk("abort.nwr", wr_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
